// File: rtl/uart_pkg.sv
// Constants, state type and line-level helper shared by the UART transmitter
// and the matching receiver.
package uart_pkg;

    localparam int UART_PERIOD    = 31;
    localparam int INIT_BIT_TIMES = 10;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } uart_tx_state_t;

    function automatic logic line_level(input uart_tx_state_t st, input logic data_bit);
        case (st)
            START:   return 1'b0;
            DATA:    return data_bit;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a byte source and the UART transmitter.
interface uart_tx_if;

    logic [7:0] data;
    logic       data_valid;
    logic       data_ack_n;

    modport master (output data, output data_valid, input data_ack_n);
    modport slave  (input data, input data_valid, output data_ack_n);

endinterface

// File: rtl/uart_tx_sync2.sv
// Generic two-flop synchronizer with asynchronous active-low reset to RST_VAL.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits, no parity, 1 or 2 stop bits, LSB first.
// A byte is taken only in IDLE while the synchronized active-low cts is low.
module uart_tx
    import uart_pkg::*;
#(
    parameter int PERIOD    = UART_PERIOD,
    parameter int STOP_BITS = 1
) (
    input  logic     clk,
    input  logic     nrst,
    uart_tx_if.slave byte_if,
    input  logic     cts,
    output logic     tx,
    output logic     busy
);

    localparam int              CW        = $clog2(PERIOD + 1);
    localparam logic [CW-1:0]   CNT_LOAD  = CW'(PERIOD);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   CNT_ZERO  = CW'(0);
    localparam logic [3:0]      INIT_LAST = 4'(INIT_BIT_TIMES - 1);
    localparam logic [3:0]      DATA_LAST = 4'd7;
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_tx_state_t r_state;
    logic [CW-1:0]  r_cnt;
    logic [3:0]     r_bit;
    logic [7:0]     r_shift;
    logic           r_tx;
    logic           r_busy;
    logic           r_ack_n;

    uart_tx_state_t w_state_nxt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [3:0]     w_bit_nxt;
    logic [7:0]     w_shift_nxt;
    logic           w_accept;
    logic           w_bit_end;
    logic           w_cts_s;

    sync2 #(.RST_VAL(1'b1)) u_cts_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (cts),
        .q    (w_cts_s)
    );

    assign w_bit_end = (r_cnt == CNT_ZERO);

    // Next-state logic; r_bit counts bit times in INIT, DATA and STOP
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit;
        w_accept    = 1'b0;
        w_cnt_nxt   = w_bit_end ? CNT_LOAD : (r_cnt - CNT_ONE);
        case (r_state)
            INIT: begin
                if (w_bit_end && (r_bit == INIT_LAST)) begin
                    w_bit_nxt   = 4'd0;
                    w_state_nxt = IDLE;
                end else if (w_bit_end) begin
                    w_bit_nxt = r_bit + 4'd1;
                end else begin
                    w_bit_nxt = r_bit;
                end
            end
            IDLE: begin
                w_cnt_nxt = CNT_LOAD;
                w_bit_nxt = 4'd0;
                if (byte_if.data_valid && !w_cts_s) begin
                    w_accept    = 1'b1;
                    w_shift_nxt = byte_if.data;
                    w_state_nxt = START;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                end else begin
                    w_state_nxt = START;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == DATA_LAST) begin
                        w_bit_nxt   = 4'd0;
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt = r_bit + 4'd1;
                    end
                end else begin
                    w_shift_nxt = r_shift;
                end
            end
            STOP: begin
                if (w_bit_end && (r_bit == STOP_LAST)) begin
                    w_bit_nxt   = 4'd0;
                    w_state_nxt = IDLE;
                end else if (w_bit_end) begin
                    w_bit_nxt = r_bit + 4'd1;
                end else begin
                    w_bit_nxt = r_bit;
                end
            end
            default: begin
                w_state_nxt = INIT;
                w_cnt_nxt   = CNT_LOAD;
                w_bit_nxt   = 4'd0;
                w_shift_nxt = 8'd0;
            end
        endcase
    end

    // State, datapath and registered outputs (outputs follow the next state)
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= INIT;
            r_cnt   <= CNT_LOAD;
            r_bit   <= 4'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b1;
            r_ack_n <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= line_level(w_state_nxt, w_shift_nxt[0]);
            r_busy  <= (w_state_nxt != IDLE);
            r_ack_n <= ~w_accept;
        end
    end

    assign tx                 = r_tx;
    assign busy               = r_busy;
    assign byte_if.data_ack_n = r_ack_n;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model plus a
// second instance with two stop bits.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int BIT      = UART_PERIOD + 1;
    localparam int INIT_CLK = 10 * BIT;
    localparam int FRAME    = 10 * BIT;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    logic cts  = 1'b1;
    logic cts2 = 1'b1;
    logic tx, busy, tx2, busy2;
    int   n_cmp = 0;
    int   n_bad = 0;

    uart_tx_if bif ();
    uart_tx_if bif2 ();

    uart_tx #(.PERIOD(UART_PERIOD), .STOP_BITS(1)) dut (
        .clk(clk), .nrst(nrst), .byte_if(bif), .cts(cts), .tx(tx), .busy(busy)
    );

    uart_tx #(.PERIOD(UART_PERIOD), .STOP_BITS(2)) dut2 (
        .clk(clk), .nrst(nrst), .byte_if(bif2), .cts(cts2), .tx(tx2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // Reference: the line is a 10-slot word {stop, byte, start}; a byte may be
    // taken once m_free is reached and cts has been low two edges earlier.
    int         m_edge  = 0;
    int         m_free  = INIT_CLK + 1;
    int         m_start = 0;
    int         m_j;
    logic       m_have  = 1'b0;
    logic [9:0] m_frame = 10'h3FF;
    logic       m_c1    = 1'b1;
    logic       m_c2    = 1'b1;
    logic       exp_tx, exp_ack_n, exp_busy;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_edge <= 0;
            m_free <= INIT_CLK + 1;
            m_have <= 1'b0;
            m_c1   <= 1'b1;
            m_c2   <= 1'b1;
        end else begin
            m_edge <= m_edge + 1;
            m_c1   <= cts;
            m_c2   <= m_c1;
            if ((m_edge + 1 >= m_free) && bif.data_valid && !m_c2) begin
                m_have  <= 1'b1;
                m_start <= m_edge + 1;
                m_frame <= {1'b1, bif.data, 1'b0};
                m_free  <= m_edge + 1 + FRAME + 1;
            end
        end
    end

    always_comb begin
        m_j       = m_edge - m_start;
        exp_tx    = 1'b1;
        exp_ack_n = 1'b1;
        exp_busy  = (m_edge < INIT_CLK);
        if (m_have && (m_j < FRAME)) begin
            exp_busy  = 1'b1;
            exp_ack_n = (m_j != 0);
            exp_tx    = m_frame[m_j / BIT];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bif.data = 8'h55; bif.data_valid = 1'b1; cts = 1'b0;
        bif2.data = 8'h00; bif2.data_valid = 1'b0; cts2 = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++;
        if (bif.data_ack_n !== 1'b1) begin n_bad++; $display("FAIL reset_ack_n: got %b want 1", bif.data_ack_n); end
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", busy); end
        nrst = 1'b1;
    endtask

    task automatic test_frame_55();
        int acks = 0;
        for (int c = 1; c <= INIT_CLK + FRAME + 20; c++) begin
            tick();
            n_cmp++;
            if ({tx, bif.data_ack_n, busy} !== {exp_tx, exp_ack_n, exp_busy}) begin
                n_bad++;
                $display("FAIL frame55 edge %0d: tx/ack_n/busy got %b%b%b want %b%b%b", m_edge, tx, bif.data_ack_n, busy, exp_tx, exp_ack_n, exp_busy);
            end
            if (!bif.data_ack_n) acks++;
            if (c > INIT_CLK + 1) bif.data = 8'($urandom);
            if (c == INIT_CLK + 10) bif.data_valid = 1'b0;
        end
        n_cmp++;
        if (acks !== 1) begin n_bad++; $display("FAIL frame55_acks: got %0d want 1", acks); end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        int first_c = 0;
        int second_c = 0;
        bif.data = 8'hA3; bif.data_valid = 1'b1;
        for (int c = 1; c <= 2 * (FRAME + 1) + 20; c++) begin
            tick();
            n_cmp++;
            if ({tx, bif.data_ack_n, busy} !== {exp_tx, exp_ack_n, exp_busy}) begin
                n_bad++;
                $display("FAIL b2b edge %0d: tx/ack_n/busy got %b%b%b want %b%b%b", m_edge, tx, bif.data_ack_n, busy, exp_tx, exp_ack_n, exp_busy);
            end
            if (!bif.data_ack_n) begin
                acks++;
                if (acks == 1) first_c = c;
                if (acks == 2) second_c = c;
            end
            if (c == FRAME + 10) bif.data_valid = 1'b0;
        end
        n_cmp++;
        if (acks !== 2) begin n_bad++; $display("FAIL b2b_acks: got %0d want 2", acks); end
        n_cmp++;
        if (second_c - first_c !== FRAME + 1) begin
            n_bad++; $display("FAIL b2b_spacing: got %0d want %0d", second_c - first_c, FRAME + 1);
        end
    endtask

    task automatic test_cts_block();
        int acks = 0;
        int delay = 0;
        cts = 1'b1; bif.data_valid = 1'b0;
        repeat (3) tick();
        bif.data_valid = 1'b1; bif.data = 8'($urandom);
        for (int c = 1; c <= 1000; c++) begin
            tick();
            n_cmp++;
            if ({tx, bif.data_ack_n, busy} !== {exp_tx, exp_ack_n, exp_busy}) begin
                n_bad++;
                $display("FAIL cts_hold edge %0d: tx/ack_n/busy got %b%b%b want %b%b%b", m_edge, tx, bif.data_ack_n, busy, exp_tx, exp_ack_n, exp_busy);
            end
            if (!bif.data_ack_n) acks++;
        end
        n_cmp++;
        if (acks !== 0) begin n_bad++; $display("FAIL cts_hold_acks: got %0d want 0", acks); end
        cts = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            n_cmp++;
            if ({tx, bif.data_ack_n, busy} !== {exp_tx, exp_ack_n, exp_busy}) begin
                n_bad++;
                $display("FAIL cts_release edge %0d: tx/ack_n/busy got %b%b%b want %b%b%b", m_edge, tx, bif.data_ack_n, busy, exp_tx, exp_ack_n, exp_busy);
            end
            if (!bif.data_ack_n) begin delay = c; break; end
        end
        n_cmp++;
        if (delay < 2 || delay > 3) begin n_bad++; $display("FAIL cts_latency: got %0d clocks want 2..3", delay); end
        bif.data_valid = 1'b0;
        for (int c = 1; c <= FRAME + 10; c++) begin
            tick();
            n_cmp++;
            if ({tx, bif.data_ack_n, busy} !== {exp_tx, exp_ack_n, exp_busy}) begin
                n_bad++;
                $display("FAIL cts_frame edge %0d: tx/ack_n/busy got %b%b%b want %b%b%b", m_edge, tx, bif.data_ack_n, busy, exp_tx, exp_ack_n, exp_busy);
            end
        end
    endtask

    task automatic test_cts_midframe();
        int acks = 0;
        bif.data = 8'hFF; bif.data_valid = 1'b1;
        for (int c = 1; c <= 700; c++) begin
            tick();
            n_cmp++;
            if ({tx, bif.data_ack_n, busy} !== {exp_tx, exp_ack_n, exp_busy}) begin
                n_bad++;
                $display("FAIL cts_mid edge %0d: tx/ack_n/busy got %b%b%b want %b%b%b", m_edge, tx, bif.data_ack_n, busy, exp_tx, exp_ack_n, exp_busy);
            end
            if (!bif.data_ack_n) acks++;
            if (c == 1 + BIT + 3 * BIT + 10) cts = 1'b1;
        end
        n_cmp++;
        if (acks !== 1) begin n_bad++; $display("FAIL cts_mid_acks: got %0d want 1", acks); end
        bif.data_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 1; c <= 1500; c++) begin
            tick();
            n_cmp++;
            if ({tx, bif.data_ack_n, busy} !== {exp_tx, exp_ack_n, exp_busy}) begin
                n_bad++;
                $display("FAIL random edge %0d: tx/ack_n/busy got %b%b%b want %b%b%b", m_edge, tx, bif.data_ack_n, busy, exp_tx, exp_ack_n, exp_busy);
            end
            bif.data_valid = ($urandom_range(0, 3) != 0);
            bif.data       = 8'($urandom);
            if ($urandom_range(0, 39) == 0) cts = ~cts;
        end
    endtask

    task automatic test_reset_midframe();
        int acks = 0;
        int ack_c = 0;
        bif.data_valid = 1'b0; cts = 1'b0;
        for (int c = 1; c <= FRAME + 80; c++) begin
            tick();
            n_cmp++;
            if ({tx, bif.data_ack_n, busy} !== {exp_tx, exp_ack_n, exp_busy}) begin
                n_bad++;
                $display("FAIL rst_settle edge %0d: tx/ack_n/busy got %b%b%b want %b%b%b", m_edge, tx, bif.data_ack_n, busy, exp_tx, exp_ack_n, exp_busy);
            end
        end
        bif.data = 8'($urandom) & 8'hDF; bif.data_valid = 1'b1;
        for (int c = 1; c <= 1 + BIT + 5 * BIT + 8; c++) begin
            tick();
            n_cmp++;
            if ({tx, bif.data_ack_n, busy} !== {exp_tx, exp_ack_n, exp_busy}) begin
                n_bad++;
                $display("FAIL rst_pre edge %0d: tx/ack_n/busy got %b%b%b want %b%b%b", m_edge, tx, bif.data_ack_n, busy, exp_tx, exp_ack_n, exp_busy);
            end
            if (c == 2) bif.data_valid = 1'b0;
        end
        #2 nrst = 1'b0;
        #1;
        n_cmp++;
        if ({tx, busy, bif.data_ack_n} !== 3'b111) begin
            n_bad++; $display("FAIL async_reset: tx/busy/ack_n got %b%b%b want 111", tx, busy, bif.data_ack_n);
        end
        tick();
        n_cmp++;
        if ({tx, busy, bif.data_ack_n} !== 3'b111) begin
            n_bad++; $display("FAIL held_reset: tx/busy/ack_n got %b%b%b want 111", tx, busy, bif.data_ack_n);
        end
        nrst = 1'b1;
        bif.data_valid = 1'b1; bif.data = 8'($urandom);
        for (int c = 1; c <= INIT_CLK + 10; c++) begin
            tick();
            n_cmp++;
            if ({tx, bif.data_ack_n, busy} !== {exp_tx, exp_ack_n, exp_busy}) begin
                n_bad++;
                $display("FAIL rst_post edge %0d: tx/ack_n/busy got %b%b%b want %b%b%b", m_edge, tx, bif.data_ack_n, busy, exp_tx, exp_ack_n, exp_busy);
            end
            if (!bif.data_ack_n) begin acks++; ack_c = c; end
        end
        n_cmp++;
        if (acks !== 1 || ack_c !== INIT_CLK + 1) begin
            n_bad++; $display("FAIL rst_reaccept: %0d acks, last at clock %0d; want 1 at %0d", acks, ack_c, INIT_CLK + 1);
        end
        bif.data_valid = 1'b0;
        for (int c = 1; c <= FRAME; c++) begin
            tick();
            n_cmp++;
            if ({tx, bif.data_ack_n, busy} !== {exp_tx, exp_ack_n, exp_busy}) begin
                n_bad++;
                $display("FAIL rst_frame edge %0d: tx/ack_n/busy got %b%b%b want %b%b%b", m_edge, tx, bif.data_ack_n, busy, exp_tx, exp_ack_n, exp_busy);
            end
        end
    endtask

    task automatic test_two_stop();
        logic found = 1'b0;
        logic e_tx, e_ack_n, e_busy;
        bif2.data = 8'h00; bif2.data_valid = 1'b1; cts2 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (!bif2.data_ack_n) begin found = 1'b1; break; end
        end
        n_cmp++;
        if (found !== 1'b1) begin n_bad++; $display("FAIL stop2_accept: no ack within 20 clocks"); end
        if (found) begin
            for (int j = 1; j <= 11 * BIT + 8; j++) begin
                tick();
                e_tx    = (j >= 9 * BIT) && (j <= 11 * BIT);
                e_ack_n = (j != 11 * BIT + 1);
                e_busy  = (j != 11 * BIT);
                n_cmp++;
                if ({tx2, bif2.data_ack_n, busy2} !== {e_tx, e_ack_n, e_busy}) begin
                    n_bad++;
                    $display("FAIL stop2 clock %0d: tx/ack_n/busy got %b%b%b want %b%b%b", j, tx2, bif2.data_ack_n, busy2, e_tx, e_ack_n, e_busy);
                end
            end
        end
        bif2.data_valid = 1'b0;
    endtask

    initial begin
        bif.data = 8'h00; bif.data_valid = 1'b0;
        test_reset();
        test_frame_55();
        test_back_to_back();
        test_cts_block();
        test_cts_midframe();
        test_random();
        test_reset_midframe();
        test_two_stop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, 8N1 (optional second stop bit), LSB first, fixed bit period in clock cycles. It pairs with the board's UART receiver and uses the same bit timing, so the two ends interoperate on one clock. A byte source offers bytes with a valid / active-low-ack handshake. Transmission starts only while the far end's active-low ready line (`cts`) is asserted.

## Interface
- `PERIOD`, default 31: bit time is `PERIOD+1` clocks (32 at default); counter is 5 bits at default, `$clog2(PERIOD+1)` in general.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2; any other value is an elaboration error.
- `clk`  in  1  Clock; all logic on rising edge.
- `nrst`  in  1  Asynchronous, active-low reset.
- `data`  in  8  Byte to send; sampled only in the acceptance cycle.
- `data_valid`  in  1  Source offers `data`.
- `data_ack_n`  out  1  Low for exactly one cycle when the byte has been taken.
- `cts`  in  1  Far-end ready, active low (0 = ready); asynchronous.
- `tx`  out  1  Serial line; idle/mark = 1.
- `busy`  out  1  High whenever not in IDLE.

## Operation
- `cts` passes through a 2-flop synchronizer (`cts_s`). Both flops reset to 1 (not ready).
- States:
  - INIT: `tx`=1; count 10 bit times (`10*(PERIOD+1)` clocks), then go to IDLE. Ignores `data_valid`.
  - IDLE: `tx`=1. If `data_valid`=1 and `cts_s`=0, latch `data` into the shift register, pulse the ack, load the bit counter with `PERIOD`, and go to START. Otherwise stay.
  - START: `tx`=0 for `PERIOD+1` clocks, then go to DATA with the bit index at 0.
  - DATA: `tx` = shift[0]. At each bit-time end, shift right. After 8 bits, go to STOP.
  - STOP: `tx`=1 for `STOP_BITS*(PERIOD+1)` clocks, then go to IDLE.
- `cts` is checked only in IDLE. Deasserting it mid-frame never truncates the frame.
- A `data_valid` drop while not in IDLE is ignored. Changes to `data` after acceptance do not affect the frame.
- `tx`, `busy` and `data_ack_n` are registered outputs; no combinational path from any input.
- Counter arithmetic is unsigned. It reloads to `PERIOD` at 0 and never wraps below 0.

## Timing
- Reset values: `tx`=1, `data_ack_n`=1, `busy`=1, state=INIT, shift register=0, `cts_s` flops=1.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronous) and the state returns to INIT. No ack is issued for the aborted byte.
- Acceptance at IDLE cycle N: in cycle N+1, `data_ack_n`=0 (one cycle only), `tx`=0, `busy`=1.
- Start bit occupies cycles N+1 .. N+32. Data bit k occupies cycles N+33+32k .. N+64+32k. Stop bit occupies N+289 .. N+320. IDLE in N+321.
- Back-to-back: the earliest next acceptance is in cycle N+321, so the next start bit begins at N+322. This gives a frame period of 321 clocks at 1 stop bit (353 at 2), with one idle-high clock between frames.
- `cts` latency: 2 clocks of synchronizer before IDLE sees it. `cts` falling at cycle M with `data_valid` held high gives acceptance at M+2.
- First possible acceptance after reset release: cycle 320 of INIT + 1.

## Structure
- `uart_pkg`:
  - `UART_PERIOD` = 31 constant, shared with the receiver.
  - `uart_tx_state_t` enum {INIT, IDLE, START, DATA, STOP}.
- Sub-module `sync2`: generic 2-flop synchronizer with async active-low reset and a reset-value parameter. Instanced for `cts` with reset value 1.
- Single always_ff for state/regs plus a single always_comb next-state block.

## Test plan
- Reset then `data_valid`=1, `data`=0x55, `cts`=0 held: no ack before INIT completes. Ack low for one cycle. `tx` = 0,1,0,1,0,1,0,1,0,1 over ten 32-clock bit slots, then high.
- `data`=0xA3, sent twice back-to-back with valid held: frames start 321 clocks apart. LSB-first pattern 1,1,0,0,0,1,0,1. Exactly two ack pulses.
- `cts`=1 with valid high for 1000 clocks: `tx` stays 1, no ack. `cts`→0: ack 2–3 clocks later.
- `cts`→1 during data bit 3 of 0xFF: frame completes with 10 slots, no further acceptance while `cts`=1.
- `nrst` pulsed low during data bit 5: `tx`=1 immediately, `busy`=1, no ack. Re-acceptance only after 320 INIT clocks.
- `STOP_BITS`=2, `data`=0x00: stop high for 64 clocks. Next acceptance at N+353.
